// File: rtl/vita49_pack.sv
// VITA-49 IF Data packetizer: header, stream ID, integer/fractional timestamp, then payload.
// Define VITA49_PACK_TRAILER_EN to append a trailer word carrying the sample-loss indicator.
module vita49_pack (
   input  logic        samp_clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [31:0] stream_id,
   input  logic [11:0] payload_len,
   input  logic [31:0] tsi,
   input  logic [63:0] tsf,
   input  logic        samp_ovf,
   input  logic [31:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic [3:0]  pkt_count
);

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      SID,
      TSI,
      TSF_HI,
      TSF_LO,
`ifdef VITA49_PACK_TRAILER_EN
      PAYLOAD,
      TRAILER
`else
      PAYLOAD
`endif
   } state_t;

`ifdef VITA49_PACK_TRAILER_EN
   localparam logic        T_BIT     = 1'b1;
   localparam logic [15:0] HDR_WORDS = 16'd6;
`else
   localparam logic        T_BIT     = 1'b0;
   localparam logic [15:0] HDR_WORDS = 16'd5;
`endif

   state_t      state;
   logic [31:0] word_q;
   logic        valid_q;
   logic        last_q;
   logic [31:0] sid_q;
   logic [31:0] tsi_q;
   logic [63:0] tsf_q;
   logic [11:0] remain;
   logic [31:0] hdr_word;
   logic        out_hs;

`ifdef VITA49_PACK_TRAILER_EN
   logic        loss_q;
`else
   logic        unused_samp_ovf;
   assign unused_samp_ovf = samp_ovf;
`endif

   assign hdr_word = {4'b0001, 1'b0, T_BIT, 2'b00, 2'b01, 2'b01, pkt_count,
                      HDR_WORDS + {4'd0, payload_len}};

   // A word moves only when m_axis_tvalid && m_axis_tready are both high on a rising edge;
   // once valid is raised for a header word, valid and data hold until that handshake.
   assign out_hs = m_axis_tvalid && m_axis_tready;

   always_ff @(posedge samp_clk) begin
      if (rst) begin
         state     <= IDLE;
         word_q    <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         sid_q     <= '0;
         tsi_q     <= '0;
         tsf_q     <= '0;
         remain    <= '0;
         pkt_count <= '0;
`ifdef VITA49_PACK_TRAILER_EN
         loss_q    <= 1'b0;
`endif
      end else begin
`ifdef VITA49_PACK_TRAILER_EN
         if (state != IDLE && state != TRAILER)
            loss_q <= loss_q | samp_ovf;
`endif
         case (state)
            IDLE: begin
               // The sample that triggers the start stays on the input until PAYLOAD.
               if (enable && s_axis_tvalid && payload_len != 12'd0) begin
                  state   <= HDR;
                  word_q  <= hdr_word;
                  valid_q <= 1'b1;
                  sid_q   <= stream_id;
                  tsi_q   <= tsi;
                  tsf_q   <= tsf;
                  remain  <= payload_len;
`ifdef VITA49_PACK_TRAILER_EN
                  loss_q  <= 1'b0;
`endif
               end
            end
            HDR: begin
               if (out_hs) begin
                  state  <= SID;
                  word_q <= sid_q;
               end
            end
            SID: begin
               if (out_hs) begin
                  state  <= TSI;
                  word_q <= tsi_q;
               end
            end
            TSI: begin
               if (out_hs) begin
                  state  <= TSF_HI;
                  word_q <= tsf_q[63:32];
               end
            end
            TSF_HI: begin
               if (out_hs) begin
                  state  <= TSF_LO;
                  word_q <= tsf_q[31:0];
               end
            end
            TSF_LO: begin
               if (out_hs) begin
                  state   <= PAYLOAD;
                  valid_q <= 1'b0;
               end
            end
            PAYLOAD: begin
               if (out_hs) begin
                  remain <= remain - 12'd1;
                  if (remain == 12'd1) begin
`ifdef VITA49_PACK_TRAILER_EN
                     state   <= TRAILER;
                     word_q  <= 32'h0100_0000 | {19'd0, loss_q | samp_ovf, 12'd0};
                     valid_q <= 1'b1;
                     last_q  <= 1'b1;
`else
                     state     <= IDLE;
                     pkt_count <= pkt_count + 4'd1;
`endif
                  end
               end
            end
`ifdef VITA49_PACK_TRAILER_EN
            TRAILER: begin
               if (out_hs) begin
                  state     <= IDLE;
                  valid_q   <= 1'b0;
                  last_q    <= 1'b0;
                  pkt_count <= pkt_count + 4'd1;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

   // Payload is a zero-latency pass-through; every other word comes from the registers.
   always_comb begin
      m_axis_tdata  = word_q;
      m_axis_tvalid = valid_q;
      m_axis_tlast  = last_q;
      s_axis_tready = 1'b0;
      if (state == PAYLOAD) begin
         m_axis_tdata  = s_axis_tdata;
         m_axis_tvalid = s_axis_tvalid;
         s_axis_tready = m_axis_tready;
`ifdef VITA49_PACK_TRAILER_EN
         m_axis_tlast  = 1'b0;
`else
         m_axis_tlast  = (remain == 12'd1);
`endif
      end
   end

endmodule

// File: tb/tb_vita49_pack.sv
// Bench for vita49_pack: a fixed packet vector table, directed multi-cycle sequences, and
// random traffic checked against a packet-level model (header words + accepted samples queue).
`timescale 1ns/1ps
module tb_vita49_pack;

`ifdef VITA49_PACK_TRAILER_EN
   localparam int TR = 1;
`else
   localparam int TR = 0;
`endif

   logic        samp_clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [31:0] stream_id;
   logic [11:0] payload_len;
   logic [31:0] tsi;
   logic [63:0] tsf;
   logic        samp_ovf;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic [3:0]  pkt_count;

   always #5 samp_clk = ~samp_clk;

   vita49_pack dut (
      .samp_clk      (samp_clk),
      .rst           (rst),
      .enable        (enable),
      .stream_id     (stream_id),
      .payload_len   (payload_len),
      .tsi           (tsi),
      .tsf           (tsf),
      .samp_ovf      (samp_ovf),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .pkt_count     (pkt_count)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // ---------------- reference model / scoreboard ----------------
   logic [32:0] exp_q[$];
   int          start_cyc[$];
   bit          model_idle = 1'b1;
   int          rem = 0;
   int          hdr_left = 0;
   bit          loss = 1'b0;
   int          m_cnt = 0;
   int          n_starts = 0;
   int          dut_beats = 0;
   int          cyc = 0;
   bit          hold_valid = 1'b0;
   logic [32:0] hold_word;
   bit          s_acc = 1'b0;
   bit          m_acc = 1'b0;
   logic [31:0] last_final = '0;
   logic [31:0] last_hdr = '0;

   always @(negedge samp_clk) begin
      logic [32:0] w;
      logic [31:0] hdr;
      cyc++;
      s_acc = s_axis_tvalid && s_axis_tready;
      m_acc = m_axis_tvalid && m_axis_tready;
      if (m_acc) dut_beats++;
      if (rst) begin
         exp_q.delete();
         model_idle = 1'b1;
         m_cnt      = 0;
         rem        = 0;
         hdr_left   = 0;
         hold_valid = 1'b0;
      end else begin
         chk(pkt_count == 4'(m_cnt), "pkt_count", 64'(pkt_count), 64'(m_cnt));
         if (hold_valid)
            chk(m_axis_tvalid && {m_axis_tlast, m_axis_tdata} == hold_word, "hold_stable",
                64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 64'({1'b1, hold_word}));
         if (model_idle) begin
            chk(!m_axis_tvalid && !s_axis_tready, "idle_quiet",
                64'({m_axis_tvalid, s_axis_tready}), 64'(0));
            if (enable && s_axis_tvalid && payload_len != 12'd0) begin
               model_idle = 1'b0;
               rem        = int'(payload_len);
               hdr_left   = 5;
               loss       = 1'b0;
               hdr = 32'h1050_0000 | (32'(TR) << 26) | (32'(m_cnt) << 16) | 32'(5 + rem + TR);
               exp_q.push_back({1'b0, hdr});
               exp_q.push_back({1'b0, stream_id});
               exp_q.push_back({1'b0, tsi});
               exp_q.push_back({1'b0, tsf[63:32]});
               exp_q.push_back({1'b0, tsf[31:0]});
               start_cyc.push_back(cyc);
               n_starts++;
            end
         end else begin
            if (rem > 0) loss = loss | samp_ovf;
            if (hdr_left == 0 && rem > 0)
               chk(s_axis_tready == m_axis_tready, "sready_pass",
                   64'(s_axis_tready), 64'(m_axis_tready));
            else
               chk(!s_axis_tready, "sready_blocked", 64'(s_axis_tready), 64'(0));
            if (s_acc) begin
               if (hdr_left != 0 || rem == 0) begin
                  chk(1'b0, "sample_taken_early", 64'(s_axis_tdata), 64'(0));
               end else begin
                  rem--;
                  exp_q.push_back({(rem == 0 && TR == 0), s_axis_tdata});
                  if (rem == 0 && TR == 1)
                     exp_q.push_back({1'b1, 32'h0100_0000 | (loss ? 32'h0000_1000 : 32'h0)});
               end
            end
            if (m_acc) begin
               if (exp_q.size() == 0) begin
                  chk(1'b0, "extra_word", 64'({m_axis_tlast, m_axis_tdata}), 64'(0));
               end else begin
                  w = exp_q.pop_front();
                  chk({m_axis_tlast, m_axis_tdata} == w, "word",
                      64'({m_axis_tlast, m_axis_tdata}), 64'(w));
                  if (hdr_left == 5) last_hdr = m_axis_tdata;
                  if (hdr_left > 0) hdr_left--;
                  if (w[32]) begin
                     last_final = m_axis_tdata;
                     model_idle = 1'b1;
                     m_cnt      = (m_cnt + 1) % 16;
                  end
               end
            end
         end
         hold_valid = m_axis_tvalid && !m_axis_tready;
         hold_word  = {m_axis_tlast, m_axis_tdata};
      end
   end

   // ---------------- driver ----------------
   int src_p    = 100;
   int rdy_mode = 0;
   int ovf_pm   = 0;
   bit ts_run   = 1'b0;
   bit rnd_cfg  = 1'b0;

   task automatic step();
      @(posedge samp_clk);
      #1;
      if (ts_run) tsf = tsf + 64'd1;
      case (rdy_mode)
         0:       m_axis_tready = 1'b1;
         1:       m_axis_tready = ~m_axis_tready;
         default: m_axis_tready = ($urandom_range(99) < 60);
      endcase
      if (!s_axis_tvalid || s_acc) begin
         s_axis_tvalid = ($urandom_range(99) < src_p);
         s_axis_tdata  = $urandom;
      end
      samp_ovf = ($urandom_range(999) < ovf_pm);
      if (rnd_cfg) begin
         stream_id   = $urandom;
         payload_len = 12'($urandom_range(0, 6));
         tsi         = $urandom;
      end
   endtask

   task automatic wait_idle(input int max, input string name);
      int k = 0;
      while (!model_idle && k < max) begin
         step();
         k++;
      end
      chk(model_idle, name, 64'(model_idle), 64'(1));
   endtask

   task automatic wait_hdr_taken(input int base, input int max, input string name);
      int k = 0;
      while (!(n_starts > base && (model_idle || hdr_left < 5)) && k < max) begin
         step();
         k++;
      end
      chk(n_starts > base, name, 64'(n_starts), 64'(base + 1));
   endtask

   task automatic wait_two_beats(input int max, input string name);
      int k = 0;
      while (!(!model_idle && hdr_left == 0 && rem == 2) && k < max) begin
         step();
         k++;
      end
      chk(!model_idle && hdr_left == 0 && rem == 2, name, 64'(rem), 64'(2));
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        s_valid;
      logic [31:0] s_data;
      logic        m_ready;
      logic        e_valid;
      logic [31:0] e_data;
      logic        e_last;
      logic        e_sready;
   } vec_t;

   vec_t vec[16];
   int   n_vec = 0;

   task automatic add(input logic sv, input logic [31:0] sd, input logic mr,
                      input logic ev, input logic [31:0] ed, input logic el, input logic esr);
      vec[n_vec].s_valid  = sv;
      vec[n_vec].s_data   = sd;
      vec[n_vec].m_ready  = mr;
      vec[n_vec].e_valid  = ev;
      vec[n_vec].e_data   = ed;
      vec[n_vec].e_last   = el;
      vec[n_vec].e_sready = esr;
      n_vec++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      logic [31:0] hdr0;
      rst = 1'b1; enable = 1'b0; stream_id = '0; payload_len = '0; tsi = '0; tsf = '0;
      samp_ovf = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;

      hdr0 = (TR == 1) ? 32'h1450_000A : 32'h1050_0009;
      add(1, 32'hC0DE_0000, 1, 0, 32'h0, 0, 0);
      add(1, 32'hC0DE_0000, 1, 1, hdr0, 0, 0);
      add(1, 32'hC0DE_0000, 1, 1, 32'hA5A5_0001, 0, 0);
      add(1, 32'hC0DE_0000, 1, 1, 32'h0000_1234, 0, 0);
      add(1, 32'hC0DE_0000, 1, 1, 32'h0000_0000, 0, 0);
      add(1, 32'hC0DE_0000, 1, 1, 32'h0000_0100, 0, 0);
      for (int k = 0; k < 4; k++)
         add(1, 32'hC0DE_0000 + 32'(k), 1, 1, 32'hC0DE_0000 + 32'(k), (k == 3 && TR == 0), 1);
      if (TR == 1) add(0, 32'h0, 1, 1, 32'h0100_0000, 1, 0);
      add(0, 32'h0, 1, 0, 32'h0, 0, 0);

      // reset values
      repeat (3) @(posedge samp_clk);
      @(negedge samp_clk);
      chk(m_axis_tvalid == 1'b0, "rst_tvalid", 64'(m_axis_tvalid), 64'(0));
      chk(m_axis_tdata == 32'h0, "rst_tdata", 64'(m_axis_tdata), 64'(0));
      chk(m_axis_tlast == 1'b0, "rst_tlast", 64'(m_axis_tlast), 64'(0));
      chk(s_axis_tready == 1'b0, "rst_sready", 64'(s_axis_tready), 64'(0));
      chk(pkt_count == 4'd0, "rst_pkt_count", 64'(pkt_count), 64'(0));

      // basic packet, cycle by cycle
      enable = 1'b1; payload_len = 12'd4; stream_id = 32'hA5A5_0001;
      tsi = 32'h0000_1234; tsf = 64'h100;
      for (int i = 0; i < n_vec; i++) begin
         @(posedge samp_clk);
         #1;
         if (i == 0) rst = 1'b0;
         s_axis_tvalid = vec[i].s_valid;
         s_axis_tdata  = vec[i].s_data;
         m_axis_tready = vec[i].m_ready;
         @(negedge samp_clk);
         chk(m_axis_tvalid == vec[i].e_valid && s_axis_tready == vec[i].e_sready &&
             m_axis_tlast == vec[i].e_last && (!vec[i].e_valid || m_axis_tdata == vec[i].e_data),
             $sformatf("vec%0d", i),
             64'({m_axis_tvalid, s_axis_tready, m_axis_tlast, m_axis_tdata}),
             64'({vec[i].e_valid, vec[i].e_sready, vec[i].e_last, vec[i].e_data}));
      end

      // count wrap: 17 back-to-back single-word packets
      base = n_starts;
      payload_len = 12'd1; src_p = 100; rdy_mode = 0; enable = 1'b1;
      for (int k = 0; k < 400 && n_starts < base + 17; k++) step();
      enable = 1'b0;
      chk(n_starts == base + 17, "wrap_starts", 64'(n_starts), 64'(base + 17));
      wait_idle(50, "wrap_done");
      step();
      chk(pkt_count == 4'd2, "wrap_pkt_count", 64'(pkt_count), 64'(2));
      for (int j = 1; j < 17; j++)
         if (base + j < start_cyc.size())
            chk(start_cyc[base + j] - start_cyc[base + j - 1] == 7 + TR, "wrap_period",
                64'(start_cyc[base + j] - start_cyc[base + j - 1]), 64'(7 + TR));

      // backpressure with ready toggling, config and timestamps changing every cycle
      rdy_mode = 1; src_p = 85; rnd_cfg = 1'b1; ts_run = 1'b1; enable = 1'b1;
      repeat (150) step();
      enable = 1'b0;
      wait_idle(100, "bp_done");

      // reset in the middle of the payload
      rnd_cfg = 1'b0; rdy_mode = 0; src_p = 100; payload_len = 12'd4; enable = 1'b1;
      wait_two_beats(60, "rst_mid_reach");
      rst = 1'b1; enable = 1'b0;
      step();
      chk(m_axis_tvalid == 1'b0, "rst_mid_tvalid", 64'(m_axis_tvalid), 64'(0));
      chk(pkt_count == 4'd0, "rst_mid_pkt_count", 64'(pkt_count), 64'(0));
      rst = 1'b0; enable = 1'b1;
      base = n_starts;
      wait_hdr_taken(base, 40, "rst_next_start");
      chk(last_hdr[19:16] == 4'd0, "rst_next_hdr_count", 64'(last_hdr[19:16]), 64'(0));
      enable = 1'b0;
      wait_idle(40, "rst_next_done");

`ifdef VITA49_PACK_TRAILER_EN
      // sample loss during the 3rd payload beat, then a clean packet
      payload_len = 12'd4; ovf_pm = 0; enable = 1'b1;
      wait_two_beats(60, "loss_reach");
      samp_ovf = 1'b1;
      step();
      wait_idle(40, "loss_done");
      chk(last_final == 32'h0100_1000, "loss_trailer", 64'(last_final), 64'h0100_1000);
      base = n_starts;
      wait_hdr_taken(base, 40, "loss_next_start");
      enable = 1'b0;
      wait_idle(40, "loss_next_done");
      chk(last_final == 32'h0100_0000, "clean_trailer", 64'(last_final), 64'h0100_0000);
`endif

      // enable dropped after the header is accepted
      payload_len = 12'd3; enable = 1'b1;
      base = n_starts;
      wait_hdr_taken(base, 40, "drop_start");
      enable = 1'b0;
      wait_idle(40, "drop_done");
      base = dut_beats;
      repeat (20) step();
      chk(dut_beats == base, "drop_no_header", 64'(dut_beats), 64'(base));

      // zero payload length never starts a packet
      payload_len = 12'd0; enable = 1'b1;
      repeat (20) step();
      chk(dut_beats == base, "len0_no_output", 64'(dut_beats), 64'(base));
      chk(m_axis_tvalid == 1'b0, "len0_tvalid", 64'(m_axis_tvalid), 64'(0));
      enable = 1'b0;

      // random traffic
      rdy_mode = 2; src_p = 70; rnd_cfg = 1'b1; ts_run = 1'b1; ovf_pm = 30; enable = 1'b1;
      repeat (700) step();
      enable = 1'b0; src_p = 100; rdy_mode = 0;
      wait_idle(200, "rand_done");
      repeat (3) step();
      chk(exp_q.size() == 0, "drain_empty", 64'(exp_q.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
